fifo_multi_queue: RTL

// NUM_QUEUES independent first-word fall-through queues with per-queue depth DEPTH.
// One enqueue port and one dequeue port, each steered by a queue id.
// Per-queue count, empty, full and almost-full status; per-queue clear.

---
 rtl/fifo_multi_queue_if.sv | 38 +++
 rtl/fifo_multi_queue.sv | 93 +++++++++
 2 files changed

// File: rtl/fifo_multi_queue_if.sv
// Enqueue/dequeue/clear handshake and per-queue status bundle for fifo_multi_queue.
interface fifo_multi_queue_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int NUM_QUEUES = 4
);
  localparam int QID_WIDTH = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                                   i__enq_valid;
  logic [QID_WIDTH-1:0]                   i__enq_qid;
  logic [DATA_WIDTH-1:0]                  i__enq_data;
  logic                                   o__enq_ready;
  logic [QID_WIDTH-1:0]                   i__deq_qid;
  logic                                   o__deq_valid;
  logic [DATA_WIDTH-1:0]                  o__deq_data;
  logic                                   i__deq_ready;
  logic                                   i__clear;
  logic [QID_WIDTH-1:0]                   i__clear_qid;
  logic [NUM_QUEUES-1:0]                  o__empty_vec;
  logic [NUM_QUEUES-1:0]                  o__full_vec;
  logic [NUM_QUEUES-1:0]                  o__afull_vec;
  logic [NUM_QUEUES-1:0][CNT_WIDTH-1:0]   oa__count;

  modport master (
    output i__enq_valid, i__enq_qid, i__enq_data, i__deq_qid, i__deq_ready,
           i__clear, i__clear_qid,
    input  o__enq_ready, o__deq_valid, o__deq_data, o__empty_vec, o__full_vec,
           o__afull_vec, oa__count
  );

  modport slave (
    input  i__enq_valid, i__enq_qid, i__enq_data, i__deq_qid, i__deq_ready,
           i__clear, i__clear_qid,
    output o__enq_ready, o__deq_valid, o__deq_data, o__empty_vec, o__full_vec,
           o__afull_vec, oa__count
  );
endinterface

// File: rtl/fifo_multi_queue.sv
// NUM_QUEUES independent FWFT queues sharing one enqueue and one dequeue port,
// each steered by a queue id, with per-queue status and flush.
module fifo_multi_queue #(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 4,
  parameter int NUM_QUEUES    = 4,
  parameter int AFULL_THRESH  = 3,
  parameter int FULL_PUSH_POP = 1
) (
  input  logic              clk,
  input  logic              reset,
  fifo_multi_queue_if.slave q_if
);
  localparam int QID_WIDTH = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic FPP     = (FULL_PUSH_POP != 0);
  // One extra bit keeps the range check meaningful when NUM_QUEUES is a power of two
  localparam logic [QID_WIDTH:0] NQ = (QID_WIDTH + 1)'(NUM_QUEUES);

  logic enq_qv, deq_qv, clr_qv;
  logic [NUM_QUEUES-1:0] enq_dec, deq_dec, clr_dec, acc, push_vec, pop_vec;
  logic [NUM_QUEUES-1:0] empty, full, afull;
  logic [NUM_QUEUES-1:0][CNT_WIDTH-1:0]  cnt;
  logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0] head;

  assign enq_qv = ({1'b0, q_if.i__enq_qid}   < NQ);
  assign deq_qv = ({1'b0, q_if.i__deq_qid}   < NQ);
  assign clr_qv = ({1'b0, q_if.i__clear_qid} < NQ);

  function automatic logic [PTR_WIDTH-1:0] ptr_nxt(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
    logic [CNT_WIDTH-1:0]             cnt_r;
    logic [PTR_WIDTH-1:0]             rd_ptr, wr_ptr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    assign enq_dec[q] = enq_qv & (q_if.i__enq_qid == QID_WIDTH'(q));
    assign deq_dec[q] = deq_qv & (q_if.i__deq_qid == QID_WIDTH'(q));
    assign clr_dec[q] = q_if.i__clear & clr_qv & (q_if.i__clear_qid == QID_WIDTH'(q));

    assign empty[q] = (cnt_r == '0);
    assign full[q]  = (cnt_r == CNT_WIDTH'(DEPTH));
    assign afull[q] = (cnt_r >= CNT_WIDTH'(AFULL_THRESH));

    assign pop_vec[q]  = ~reset & q_if.i__deq_ready & deq_dec[q] & ~empty[q] & ~clr_dec[q];
    // A full queue frees a slot in the same cycle only if it is being popped
    assign acc[q]      = enq_dec[q] & ~clr_dec[q] & (~full[q] | (FPP & pop_vec[q]));
    assign push_vec[q] = ~reset & q_if.i__enq_valid & acc[q];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_r  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else if (clr_dec[q]) begin
        cnt_r  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_vec[q]) wr_ptr <= ptr_nxt(wr_ptr);
        if (pop_vec[q])  rd_ptr <= ptr_nxt(rd_ptr);
        case ({push_vec[q], pop_vec[q]})
          2'b10:   cnt_r <= cnt_r + 1'b1;
          2'b01:   cnt_r <= cnt_r - 1'b1;
          default: cnt_r <= cnt_r;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push_vec[q]) mem[wr_ptr] <= q_if.i__enq_data;
    end

    assign head[q] = mem[rd_ptr];
    assign cnt[q]  = cnt_r;
  end

  always_comb begin
    q_if.o__deq_data = '0;
    for (int q = 0; q < NUM_QUEUES; q++)
      if (deq_dec[q]) q_if.o__deq_data = head[q];
  end

  assign q_if.o__enq_ready = ~reset & (|acc);
  assign q_if.o__deq_valid = ~reset & (|(deq_dec & ~empty & ~clr_dec));
  assign q_if.o__empty_vec = empty;
  assign q_if.o__full_vec  = full;
  assign q_if.o__afull_vec = afull;
  assign q_if.oa__count    = cnt;
endmodule
